// File: rtl/vector_dot_product.sv
// vector_dot_product: fp16 dot product of two packed 3-lane vectors.
// Three parallel fp16 multipliers form the lane products, then a single
// fp16 adder is reused twice to sum them in the fixed order (x+y)+z.
//
// Ports (vector_dot_product):
//   clk    - clock, all logic on posedge
//   rst_n  - synchronous active-low reset (cores see ~rst_n as areset)
//   en     - start request, operands sampled on the same edge (IDLE only)
//   vec_a  - {ax, ay, az}, fp16 each
//   vec_b  - {bx, by, bz}, fp16 each
//   dot_q  - fp16 result, held until the next result
//   valid  - one-cycle pulse when dot_q updates
//   busy   - high while a request is in flight

package vector_dot_product_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  // Round-to-nearest-even and pack: value = sig * 2^lsb_exp (unbiased).
  function automatic logic [15:0] fp16_round_pack(input logic        sign,
                                                  input logic [41:0] sig,
                                                  input int          lsb_exp);
    int          p;
    int          e;
    int          s;
    logic [41:0] m;
    logic [41:0] rem_mask;
    logic        guard;
    logic        sticky;
    logic        is_norm;
    p        = 0;
    m        = '0;
    rem_mask = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (sig == 42'd0) return {sign, 15'h0000};
    for (int i = 0; i < 42; i++) begin
      if ((sig >> i) != 42'd0) p = i;
    end
    e = p + lsb_exp + 15;
    s = p - 10;
    // Below the normal range: shift further so the result lands at exp field 0/1.
    if (e < 1) begin
      s = s + 1 - e;
      e = 1;
    end
    if (s <= 0) begin
      m = sig << (-s);
    end else begin
      m        = sig >> s;
      guard    = ((sig >> (s - 1)) & 42'd1) != 42'd0;
      rem_mask = (42'd1 << (s - 1)) - 42'd1;
      sticky   = (sig & rem_mask) != 42'd0;
      if (guard && (sticky || m[0])) m = m + 42'd1;
    end
    // Rounding carried out of the significand.
    if (m >= 42'd2048) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 31) return {sign, 5'h1f, 10'h000};
    is_norm = m >= 42'd1024;
    return {sign, is_norm ? 5'(e) : 5'd0, m[9:0]};
  endfunction

  function automatic logic fp16_is_nan(input fp16_t f);
    return (f.exp == 5'h1f) && (f.frac != 10'h000);
  endfunction

  function automatic logic fp16_is_inf(input fp16_t f);
    return (f.exp == 5'h1f) && (f.frac == 10'h000);
  endfunction

  function automatic logic fp16_is_zero(input fp16_t f);
    return (f.exp == 5'h00) && (f.frac == 10'h000);
  endfunction

  // Significand with hidden bit; subnormals use exponent 1 with hidden bit 0.
  function automatic logic [10:0] fp16_mant(input fp16_t f);
    return {(f.exp != 5'h00), f.frac};
  endfunction

  function automatic int fp16_exp(input fp16_t f);
    return (f.exp == 5'h00) ? 1 : int'(f.exp);
  endfunction

  function automatic logic [15:0] fp16_mul_c(input logic [15:0] a, input logic [15:0] b);
    fp16_t       fa;
    fp16_t       fb;
    logic        s;
    logic [21:0] prod;
    fa = a;
    fb = b;
    s  = fa.sign ^ fb.sign;
    if (fp16_is_nan(fa) || fp16_is_nan(fb)) return FP16_QNAN;
    if (fp16_is_inf(fa) || fp16_is_inf(fb)) begin
      if (fp16_is_zero(fa) || fp16_is_zero(fb)) return FP16_QNAN;
      return {s, 5'h1f, 10'h000};
    end
    prod = 22'(fp16_mant(fa)) * 22'(fp16_mant(fb));
    return fp16_round_pack(s, 42'(prod), fp16_exp(fa) + fp16_exp(fb) - 50);
  endfunction

  // Exact integer sum at the smaller exponent, rounded once at the end.
  function automatic logic [15:0] fp16_add_c(input logic [15:0] a, input logic [15:0] b);
    fp16_t       fa;
    fp16_t       fb;
    int          ea;
    int          eb;
    int          emin;
    logic [41:0] sa;
    logic [41:0] sb;
    logic [41:0] sum;
    logic        s;
    fa = a;
    fb = b;
    if (fp16_is_nan(fa) || fp16_is_nan(fb)) return FP16_QNAN;
    if (fp16_is_inf(fa) && fp16_is_inf(fb) && (fa.sign != fb.sign)) return FP16_QNAN;
    if (fp16_is_inf(fa)) return a;
    if (fp16_is_inf(fb)) return b;
    ea   = fp16_exp(fa);
    eb   = fp16_exp(fb);
    emin = (ea < eb) ? ea : eb;
    sa   = 42'(fp16_mant(fa)) << (ea - emin);
    sb   = 42'(fp16_mant(fb)) << (eb - emin);
    if (fa.sign == fb.sign) begin
      sum = sa + sb;
      s   = fa.sign;
    end else if (sa >= sb) begin
      sum = sa - sb;
      s   = fa.sign;
    end else begin
      sum = sb - sa;
      s   = fb.sign;
    end
    // Exact zero is +0 unless both operands were -0.
    if (sum == 42'd0) s = fa.sign & fb.sign;
    return fp16_round_pack(s, sum, emin - 25);
  endfunction

endpackage

// fp16_delay: LAT-1 register stages after a combinational core, so a result
// is captured on the LAT-th edge after the operands are applied.
module fp16_delay #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk_i,
  input  logic        areset_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);
  if (LAT <= 1) begin : g_comb
    logic unused_ctl;
    assign unused_ctl = clk_i ^ areset_i;
    assign q_o        = d_i;
  end else begin : g_pipe
    logic [15:0] pipe_q [LAT-1];
    always_ff @(posedge clk_i) begin
      if (areset_i) begin
        for (int i = 0; i < int'(LAT) - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < int'(LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign q_o = pipe_q[LAT-2];
  end
endmodule

// fp16mul: fixed-latency fp16 multiplier core.
module fp16mul
  import vector_dot_product_pkg::*;
#(
  parameter int unsigned LAT = 6
) (
  input  logic        clk_i,
  input  logic        areset_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] q_o
);
  logic [15:0] res_c;
  assign res_c = fp16_mul_c(a_i, b_i);

  fp16_delay #(.LAT(LAT)) u_delay (
    .clk_i    (clk_i),
    .areset_i (areset_i),
    .d_i      (res_c),
    .q_o      (q_o)
  );
endmodule

// fp16add: fixed-latency fp16 adder core.
module fp16add
  import vector_dot_product_pkg::*;
#(
  parameter int unsigned LAT = 10
) (
  input  logic        clk_i,
  input  logic        areset_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] q_o
);
  logic [15:0] res_c;
  assign res_c = fp16_add_c(a_i, b_i);

  fp16_delay #(.LAT(LAT)) u_delay (
    .clk_i    (clk_i),
    .areset_i (areset_i),
    .d_i      (res_c),
    .q_o      (q_o)
  );
endmodule

module vector_dot_product #(
  parameter int unsigned MUL_LAT = 6,
  parameter int unsigned ADD_LAT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [47:0] vec_a,
  input  logic [47:0] vec_b,
  output logic [15:0] dot_q,
  output logic        valid,
  output logic        busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD1 = 2'd2,
    ST_ADD2 = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [47:0]        a_q, a_d;
  logic [47:0]        b_q, b_d;
  logic [15:0]        px_q, px_d;
  logic [15:0]        py_q, py_d;
  logic [15:0]        pz_q, pz_d;
  logic [15:0]        s_q, s_d;
  logic [15:0]        dot_d;
  logic               valid_q, valid_d;

  logic               core_areset;
  logic [15:0]        mul_x, mul_y, mul_z;
  logic [15:0]        add_a_c, add_b_c, add_q;
  logic               mul_done_c, add_done_c;

  assign core_areset = ~rst_n;

  // Lane multipliers read the latched operands for the whole MUL window.
  fp16mul #(.LAT(MUL_LAT)) u_mul_x (
    .clk_i (clk), .areset_i (core_areset),
    .a_i (a_q[47:32]), .b_i (b_q[47:32]), .q_o (mul_x)
  );
  fp16mul #(.LAT(MUL_LAT)) u_mul_y (
    .clk_i (clk), .areset_i (core_areset),
    .a_i (a_q[31:16]), .b_i (b_q[31:16]), .q_o (mul_y)
  );
  fp16mul #(.LAT(MUL_LAT)) u_mul_z (
    .clk_i (clk), .areset_i (core_areset),
    .a_i (a_q[15:0]), .b_i (b_q[15:0]), .q_o (mul_z)
  );

  // Shared adder: (px + py) in ADD1, then (s + pz) in ADD2.
  assign add_a_c = (state_q == ST_ADD2) ? s_q  : px_q;
  assign add_b_c = (state_q == ST_ADD2) ? pz_q : py_q;

  fp16add #(.LAT(ADD_LAT)) u_add (
    .clk_i (clk), .areset_i (core_areset),
    .a_i (add_a_c), .b_i (add_b_c), .q_o (add_q)
  );

  assign mul_done_c = (cnt_q == CNT_W'(MUL_LAT - 1));
  assign add_done_c = (cnt_q == CNT_W'(ADD_LAT - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pz_q    <= '0;
      s_q     <= '0;
      dot_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pz_q    <= pz_d;
      s_q     <= s_d;
      dot_q   <= dot_d;
      valid_q <= valid_d;
    end
  end

  // Sequencer: accept, multiply, two adds, publish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    px_d    = px_q;
    py_d    = py_q;
    pz_d    = pz_q;
    s_d     = s_q;
    dot_d   = dot_q;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          a_d     = vec_a;
          b_d     = vec_b;
          cnt_d   = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          px_d    = mul_x;
          py_d    = mul_y;
          pz_d    = mul_z;
          cnt_d   = '0;
          state_d = ST_ADD1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ADD1: begin
        if (add_done_c) begin
          s_d     = add_q;
          cnt_d   = '0;
          state_d = ST_ADD2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ADD2: begin
        if (add_done_c) begin
          dot_d   = add_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign valid = valid_q;
  // Decoded straight from the state register.
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vector_dot_product.sv
// Directed bench for vector_dot_product: default latencies plus a
// MUL_LAT=1/ADD_LAT=1 instance sharing clock and reset.
module tb_vector_dot_product;

  logic        clk;
  logic        rst_n;
  logic        en, en_f;
  logic [47:0] vec_a, vec_b, vec_a_f, vec_b_f;
  logic [15:0] dot_q, dot_q_f;
  logic        valid, busy, valid_f, busy_f;

  int n_cmp  = 0;
  int n_fail = 0;

  vector_dot_product dut (
    .clk (clk), .rst_n (rst_n), .en (en), .vec_a (vec_a), .vec_b (vec_b),
    .dot_q (dot_q), .valid (valid), .busy (busy)
  );

  vector_dot_product #(.MUL_LAT(1), .ADD_LAT(1)) dut_fast (
    .clk (clk), .rst_n (rst_n), .en (en_f), .vec_a (vec_a_f), .vec_b (vec_b_f),
    .dot_q (dot_q_f), .valid (valid_f), .busy (busy_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle index k=1 is the cycle right after the current point; lat=0 means timeout.
  task automatic wait_valid(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (valid) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      tick();
    end
  endtask

  task automatic wait_valid_fast(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (valid_f) begin
        lat = k;
        break;
      end
      if (busy_f) bcnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    int nvalid;
    rst_n = 1'b0; en = 1'b0; en_f = 1'b0;
    vec_a = '0; vec_b = '0; vec_a_f = '0; vec_b_f = '0;
    tick(); tick();
    n_cmp++; if (dot_q !== 16'h0000) begin n_fail++; $display("FAIL reset_dot: got %h want 0000", dot_q); end
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: valid=%b busy=%b want 0 0", valid, busy); end
    n_cmp++; if (dot_q_f !== 16'h0000 || valid_f !== 1'b0 || busy_f !== 1'b0) begin n_fail++; $display("FAIL reset_fast: dot=%h valid=%b busy=%b want 0000 0 0", dot_q_f, valid_f, busy_f); end
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 50; i++) begin
      if (valid || busy || dot_q != 16'h0000) nvalid++;
      tick();
    end
    n_cmp++; if (nvalid !== 0) begin n_fail++; $display("FAIL idle_quiet: %0d bad cycles want 0", nvalid); end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    vec_a = 48'h3C00_4000_4200; vec_b = 48'h4400_4500_4600; en = 1'b1;
    tick(); en = 1'b0;
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 27) begin n_fail++; $display("FAIL basic_latency: got %0d want 27", lat); end
    n_cmp++; if (bcnt !== 26) begin n_fail++; $display("FAIL basic_busy: got %0d cycles want 26", bcnt); end
    n_cmp++; if (dot_q !== 16'h5000) begin n_fail++; $display("FAIL basic_dot: got %h want 5000", dot_q); end
    tick();
    n_cmp++; if (valid !== 1'b0 || dot_q !== 16'h5000) begin n_fail++; $display("FAIL basic_hold: valid=%b dot=%h want 0 5000", valid, dot_q); end
  endtask

  task automatic test_sign_zero();
    int lat, bcnt;
    vec_a = 48'h3C00_4000_4200; vec_b = 48'hBC00_C000_C200; en = 1'b1;
    tick(); en = 1'b0;
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 27 || dot_q !== 16'hCB00) begin n_fail++; $display("FAIL sign_dot: lat=%0d dot=%h want 27 cb00", lat, dot_q); end
    vec_a = 48'h3C00_0000_0000; vec_b = 48'h0000_3C00_0000; en = 1'b1;
    tick(); en = 1'b0;
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 27 || dot_q !== 16'h0000) begin n_fail++; $display("FAIL zero_dot: lat=%0d dot=%h want 27 0000", lat, dot_q); end
  endtask

  task automatic test_special();
    int lat, bcnt;
    vec_a = 48'h7C00_0000_0000; vec_b = 48'h3C00_0000_0000; en = 1'b1;
    tick(); en = 1'b0;
    wait_valid(lat, bcnt);
    n_cmp++; if (dot_q !== 16'h7C00) begin n_fail++; $display("FAIL inf_dot: got %h want 7c00", dot_q); end
    vec_a = 48'h7C00_0000_0000; vec_b = 48'h0000_0000_0000; en = 1'b1;
    tick(); en = 1'b0;
    wait_valid(lat, bcnt);
    n_cmp++; if (dot_q[14:10] !== 5'h1f || dot_q[9:0] == 10'h000) begin n_fail++; $display("FAIL nan_dot: got %h want a NaN", dot_q); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    vec_a = 48'h3C00_4000_4200; vec_b = 48'h4400_4500_4600; en = 1'b1;
    tick(); en = 1'b0;
    repeat (4) tick();
    // Request at E0+5 while busy must be dropped.
    vec_a = 48'h4400_4400_4400; vec_b = 48'h4400_4400_4400; en = 1'b1;
    tick(); en = 1'b0;
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 22 || dot_q !== 16'h5000) begin n_fail++; $display("FAIL drop_first: lat=%0d dot=%h want 22 5000", lat, dot_q); end
    vec_a = 48'h4000_4000_4000; vec_b = 48'h3800_3800_3800; en = 1'b1;
    tick(); en = 1'b0;
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: valid=%b busy=%b want 0 1", valid, busy); end
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 27 || bcnt !== 26 || dot_q !== 16'h4200) begin n_fail++; $display("FAIL b2b_second: lat=%0d busy=%0d dot=%h want 27 26 4200", lat, bcnt, dot_q); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, nvalid;
    vec_a = 48'h3C00_4000_4200; vec_b = 48'h4400_4500_4600; en = 1'b1;
    tick(); en = 1'b0;
    repeat (11) tick();
    rst_n = 1'b0; en = 1'b1;
    tick();
    rst_n = 1'b1; en = 1'b0;
    n_cmp++; if (dot_q !== 16'h0000 || valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_state: dot=%h valid=%b busy=%b want 0000 0 0", dot_q, valid, busy); end
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid || busy) nvalid++;
      tick();
    end
    n_cmp++; if (nvalid !== 0 || dot_q !== 16'h0000) begin n_fail++; $display("FAIL midreset_quiet: bad=%0d dot=%h want 0 0000", nvalid, dot_q); end
    vec_a = 48'h3C00_4000_4200; vec_b = 48'hBC00_C000_C200; en = 1'b1;
    tick(); en = 1'b0;
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 27 || dot_q !== 16'hCB00) begin n_fail++; $display("FAIL midreset_recover: lat=%0d dot=%h want 27 cb00", lat, dot_q); end
    tick();
  endtask

  task automatic test_param_fast();
    int lat, bcnt;
    vec_a_f = 48'h3C00_4000_4200; vec_b_f = 48'h4400_4500_4600; en_f = 1'b1;
    tick(); en_f = 1'b0;
    wait_valid_fast(lat, bcnt);
    n_cmp++; if (lat !== 4 || bcnt !== 3) begin n_fail++; $display("FAIL fast_timing: lat=%0d busy=%0d want 4 3", lat, bcnt); end
    n_cmp++; if (dot_q_f !== 16'h5000) begin n_fail++; $display("FAIL fast_dot: got %h want 5000", dot_q_f); end
    tick();
    n_cmp++; if (valid_f !== 1'b0 || busy_f !== 1'b0) begin n_fail++; $display("FAIL fast_pulse: valid=%b busy=%b want 0 0", valid_f, busy_f); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_zero();
    test_special();
    test_back_to_back();
    test_reset_mid();
    test_param_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_dot_product.md
# vector_dot_product

Computes the fp16 dot product of two 3-component vectors packed as 48-bit words {x, y, z}. It sits directly downstream of vector_subtraction: its vec_q/valid output feeds this block's vec_a/en, typically to form a difference vector's squared length or its projection onto a direction. It uses three parallel fp16mul cores and one time-multiplexed fp16add core, sequenced by a small FSM. It produces one 16-bit fp16 result with a single-cycle valid pulse.

## Interface
- MUL_LAT, 6, fixed latency of fp16mul in cycles (≥1)
- ADD_LAT, 10, fixed latency of fp16add in cycles (≥1)

- clk  input  1  single clock; all logic on posedge
- rst_n  input  1  reset, synchronous and active-low; also drives the cores' areset as ~rst_n
- en  input  1  start request; operands are sampled on the same edge
- vec_a  input  48  {ax[47:32], ay[31:16], az[15:0]}, fp16 each
- vec_b  input  48  {bx, by, bz}, same packing
- dot_q  output  16  fp16 result ax·bx + ay·by + az·bz; held until the next result
- valid  output  1  one-cycle pulse when dot_q updates
- busy  output  1  high from the cycle after acceptance until the cycle valid is asserted (exclusive)

## Operation
- Registers: a_r, b_r (48b), px/py/pz (16b), s_r (16b), dot_q, valid, state, cnt (sized for max(MUL_LAT, ADD_LAT)).
- FSM states:
  - IDLE: busy=0. When en=1, latch a_r←vec_a and b_r←vec_b, set cnt←0, go to MUL. When en=0, stay.
  - MUL: the three fp16mul cores take a_r/b_r lanes. cnt increments each cycle. When cnt==MUL_LAT-1: latch px/py/pz from the core outputs, cnt←0, go to ADD1.
  - ADD1: adder inputs are (px, py). When cnt==ADD_LAT-1: s_r←adder q, cnt←0, go to ADD2.
  - ADD2: adder inputs are (s_r, pz). When cnt==ADD_LAT-1: dot_q←adder q, valid←1, go to IDLE.
- valid is registered. It is high for exactly one cycle, the first cycle back in IDLE, and is cleared on the next edge.
- en is ignored while state≠IDLE. A request arriving during busy is dropped, not queued.
- Back-to-back operation: en high in the cycle valid=1 (state IDLE) is accepted.
- The adder input mux is selected by state and is held constant for the full ADD_LAT window of each add. The cores are not pipelined across requests.
- Arithmetic: summation order is fixed as (x+y)+z. The result is whatever fp16mul/fp16add produce, with no extra rounding, saturation or flushing. NaN/Inf propagate from the cores.
- Reset (rst_n=0 at a posedge), regardless of state: state←IDLE, cnt←0, valid←0, dot_q←16'h0000, busy=0, a_r/b_r/px/py/pz/s_r←0.
  - Any in-flight computation is discarded and no valid is produced for it.
  - en is ignored during reset cycles.

## Timing
- Reset values: dot_q=16'h0000, valid=0, busy=0.
- Acceptance edge is E0 (en=1 in IDLE).
  - busy is high for cycles E0+1 … E0+MUL_LAT+2·ADD_LAT.
  - valid is high in cycle E0+MUL_LAT+2·ADD_LAT+1, which is 27 cycles after acceptance with the defaults.
- Throughput: one result per MUL_LAT+2·ADD_LAT+1 cycles at most.
- dot_q changes only on the edge that raises valid.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, release, keep en=0 for 50 cycles -> valid never asserts, dot_q=0x0000, busy=0.
- Basic product: vec_a={0x3C00,0x4000,0x4200} (1,2,3), vec_b={0x4400,0x4500,0x4600} (4,5,6), en for 1 cycle -> valid exactly 27 cycles later with dot_q=0x5000 (32.0); busy high for exactly 26 cycles before it.
- Sign and zero: (1,2,3)·(0xBC00,0xC000,0xC200) -> dot_q=0xCB00 (−14.0); then (1,0,0)·(0,1,0) -> dot_q=0x0000.
- Busy drop and back-to-back: pulse en again 5 cycles after the first acceptance with different operands -> ignored, only one valid. Then assert en in the valid cycle -> second request accepted, and its valid arrives 27 cycles later.
- Reset mid-operation: assert rst_n=0 for 1 cycle at E0+12 -> no valid from that request, dot_q=0x0000. A new request after reset completes with the correct value at the correct latency.
- Parameter sweep: instantiate with MUL_LAT=1, ADD_LAT=1 -> the basic product returns 0x5000 with valid at E0+4.
